// File: rtl/order_pkg.sv
// Shared frame definitions for the order encoder / order sorter pair.
package order_pkg;

    // Default header bytes identifying the frame type.
    localparam logic [7:0] DEF_HDR_WRITE = 8'h57;
    localparam logic [7:0] DEF_HDR_READ  = 8'h52;

    // Width of the length field; always carried as two bytes on the wire.
    localparam int unsigned DEF_LEN_W = 16;

    // Byte offsets of each field within a frame.
    localparam int unsigned OFS_HDR    = 0;
    localparam int unsigned OFS_ADDR   = 1;
    localparam int unsigned OFS_LEN_HI = 2;
    localparam int unsigned OFS_LEN_LO = 3;
    localparam int unsigned OFS_DATA   = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        LEN_HI,
        LEN_LO,
        DATA
    } order_state_e;

endpackage

// File: rtl/order_encoder.sv
// Byte-serial command frame transmitter feeding an FTDI-style write FIFO.
module order_encoder
    import order_pkg::*;
#(
    parameter logic [7:0]  HDR_WRITE = DEF_HDR_WRITE,
    parameter logic [7:0]  HDR_READ  = DEF_HDR_READ,
    parameter int unsigned LEN_W     = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_is_read,
    input  logic [7:0]       cmd_address,
    input  logic [LEN_W-1:0] cmd_length,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       out_data,
    output logic             out_wr,
    input  logic             out_full,
    output logic             busy,
    output logic [15:0]      frame_count
);

    order_state_e     state_q, state_d;
    logic             is_read_q, is_read_d;
    logic [7:0]       address_q, address_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_wr_q, out_wr_d;
    logic [15:0]      frame_count_q, frame_count_d;

    // State and datapath registers; reset truncates any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            is_read_q     <= 1'b0;
            address_q     <= '0;
            remaining_q   <= '0;
            out_data_q    <= '0;
            out_wr_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            address_q     <= address_d;
            remaining_q   <= remaining_d;
            out_data_q    <= out_data_d;
            out_wr_q      <= out_wr_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next-state, byte selection and handshakes.
    // The length is emitted from the remaining counter before DATA starts
    // decrementing it, so no separate copy of the length is kept.
    always_comb begin
        state_d       = state_q;
        is_read_d     = is_read_q;
        address_d     = address_q;
        remaining_d   = remaining_q;
        out_data_d    = out_data_q;
        out_wr_d      = 1'b0;
        frame_count_d = frame_count_q;
        cmd_ready     = 1'b0;
        wdata_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    is_read_d   = cmd_is_read;
                    address_d   = cmd_address;
                    remaining_d = cmd_length;
                    state_d     = HDR;
                end
            end
            HDR: begin
                if (!out_full) begin
                    out_data_d = is_read_q ? HDR_READ : HDR_WRITE;
                    out_wr_d   = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (!out_full) begin
                    out_data_d = address_q;
                    out_wr_d   = 1'b1;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (!out_full) begin
                    out_data_d = remaining_q[15:8];
                    out_wr_d   = 1'b1;
                    state_d    = LEN_LO;
                end
            end
            LEN_LO: begin
                if (!out_full) begin
                    out_data_d = remaining_q[7:0];
                    out_wr_d   = 1'b1;
                    if (!is_read_q && (remaining_q != '0)) begin
                        state_d = DATA;
                    end else begin
                        state_d       = IDLE;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end
            end
            DATA: begin
                wdata_ready = !out_full;
                if (wdata_valid && !out_full) begin
                    out_data_d  = wdata;
                    out_wr_d    = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d       = IDLE;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data    = out_data_q;
    assign out_wr      = out_wr_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_order_encoder.sv
// Self-checking bench: frames are predicted as byte lists from the command
// fields and the payload the bench offers, then matched against FIFO strobes.
module tb_order_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_read = 1'b0;
    logic [7:0]  cmd_address = '0;
    logic [15:0] cmd_length = '0;
    logic [7:0]  wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [7:0]  out_data;
    logic        out_wr;
    logic        out_full = 1'b0;
    logic        busy;
    logic [15:0] frame_count;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_fc = '0;
    logic [7:0]  dir_pay[$];

    order_encoder #(
        .HDR_WRITE (8'h57),
        .HDR_READ  (8'h52),
        .LEN_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_is_read (cmd_is_read),
        .cmd_address (cmd_address),
        .cmd_length  (cmd_length),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .out_data    (out_data),
        .out_wr      (out_wr),
        .out_full    (out_full),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one frame starting at the current negedge. fs/fl force out_full for
    // cycles [fs, fs+fl); ss/sl force wdata_valid low for cycles [ss, ss+sl).
    task automatic run_frame(input bit rd, input logic [7:0] addr, input logic [15:0] len,
                             input int full_pct, input int starve_pct,
                             input int fs, input int fl, input int ss, input int sl);
        logic [7:0] exp_q[$];
        logic [7:0] pay[$];
        logic [7:0] b;
        int  pidx = 0;
        int  cyc = 0;
        int  budget;
        bit  prev_full = 1'b0;
        bit  done = 1'b0;
        bit  starve;
        bit  stall_free;

        stall_free = (full_pct == 0) && (starve_pct == 0) && (fl == 0) && (sl == 0);
        budget = (int'(len) + 8) * 8 + 100;
        exp_q.push_back(rd ? 8'h52 : 8'h57);
        exp_q.push_back(addr);
        exp_q.push_back(len[15:8]);
        exp_q.push_back(len[7:0]);
        if (!rd) begin
            for (int i = 0; i < int'(len); i++) begin
                b = (i < dir_pay.size()) ? dir_pay[i] : 8'($urandom);
                pay.push_back(b);
                exp_q.push_back(b);
            end
        end
        dir_pay.delete();

        chk("cmd_ready_idle", cmd_ready, 1);
        chk("busy_idle", busy, 0);
        cmd_valid   = 1'b1;
        cmd_is_read = rd;
        cmd_address = addr;
        cmd_length  = len;
        out_full    = 1'b0;
        wdata_valid = 1'b0;

        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            cmd_valid   = 1'b0;
            cmd_address = 8'($urandom);
            cmd_length  = 16'($urandom);
            if (out_wr) begin
                if (prev_full) chk("wr_while_full", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("extra_strobe", 1, 0);
                end else begin
                    chk("byte", out_data, exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        done = 1'b1;
                        exp_fc++;
                        chk("busy_end", busy, 0);
                        chk("frame_count", frame_count, exp_fc);
                        if (stall_free) chk("frame_cycles", cyc, int'(len) * (rd ? 0 : 1) + 5);
                    end
                end
            end
            if (!done) begin
                chk("busy_mid", busy, 1);
                starve      = ((cyc >= ss) && (cyc < ss + sl)) || ($urandom_range(99) < starve_pct);
                out_full    = ((cyc >= fs) && (cyc < fs + fl)) || ($urandom_range(99) < full_pct);
                wdata_valid = !starve;
                wdata       = (pidx < pay.size()) ? pay[pidx] : 8'($urandom);
                #1;
                if (rd) chk("rd_no_wready", wdata_ready, 0);
                if (wdata_ready && out_full) chk("wready_while_full", 1, 0);
                if (wdata_ready && wdata_valid) pidx++;
                prev_full = out_full;
            end
        end
        if (!done) chk("frame_timeout", 0, 1);
        chk("payload_consumed", pidx, rd ? 0 : int'(len));
        out_full    = 1'b0;
        wdata_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wdata_ready", wdata_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed write: 57 12 00 03 AA BB CC back-to-back.
        dir_pay = '{8'hAA, 8'hBB, 8'hCC};
        run_frame(1'b0, 8'h12, 16'd3, 0, 0, 0, 0, 0, 0);
        // Directed read, issued in the cycle right after the previous frame ends.
        run_frame(1'b1, 8'h40, 16'h0102, 0, 20, 0, 0, 0, 0);
        // Backpressure held through LEN_HI.
        run_frame(1'b0, 8'h21, 16'd4, 0, 0, 3, 5, 0, 0);
        // Payload starvation mid-DATA.
        run_frame(1'b0, 8'h35, 16'd8, 0, 0, 0, 0, 7, 3);
        // Zero-length write, then an immediate follow-up command.
        run_frame(1'b0, 8'h77, 16'd0, 0, 0, 0, 0, 0, 0);
        run_frame(1'b1, 8'h78, 16'd0, 0, 0, 0, 0, 0, 0);

        // Reset while the address byte is pending.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_is_read = 1'b0;
        cmd_address = 8'h33;
        cmd_length  = 16'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_hdr", out_wr, 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_wr", out_wr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_count", frame_count, 0);
        exp_fc = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(1'b1, 8'h44, 16'h0A0B, 0, 0, 0, 0, 0, 0);

        // Randomized mix of reads and writes under random backpressure.
        for (int n = 0; n < 30; n++) begin
            run_frame(1'($urandom), 8'($urandom), 16'($urandom_range(20)),
                      $urandom_range(30), $urandom_range(30), 0, 0, 0, 0);
            if ($urandom_range(1) == 1) @(negedge clk);
        end

        // Maximum length write.
        run_frame(1'b0, 8'hFE, 16'hFFFF, 0, 0, 0, 0, 0, 0);

        repeat (3) begin
            @(negedge clk);
            chk("idle_no_strobe", out_wr, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
